// File: rtl/imem_load_ctrl.sv
// Instruction-memory port arbiter: fetch path passes straight through in IDLE,
// boot/debug loader streams words into consecutive addresses while the CPU stalls.
module imem_load_ctrl #(
  parameter int unsigned        AD_WD   = 16,
  parameter int unsigned        DATA_WD = 32,
  parameter int unsigned        DEPTH   = 100,
  parameter logic [DATA_WD-1:0] NOP     = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AD_WD-1:0]   cpu_pc,
  output logic [DATA_WD-1:0] cpu_instr,
  output logic               cpu_stall,
  input  logic               ld_start,
  input  logic [AD_WD-1:0]   ld_base,
  input  logic [AD_WD-1:0]   ld_len,
  input  logic               ld_abort,
  input  logic               ld_valid,
  input  logic [DATA_WD-1:0] ld_data,
  output logic               ld_ready,
  output logic               ld_busy,
  output logic               ld_done,
  output logic               ld_err,
  output logic [AD_WD-1:0]   ld_count,
  output logic [AD_WD-1:0]   mem_address,
  output logic               mem_write,
  output logic [DATA_WD-1:0] mem_data_in,
  input  logic [DATA_WD-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AD_WD-1:0] r_wr_ptr;
  logic [AD_WD-1:0] r_remaining;
  logic [AD_WD-1:0] r_count;
  logic             r_done;
  logic             r_err;
  logic [AD_WD-1:0] w_wr_ptr_nxt;
  logic [AD_WD-1:0] w_remaining_nxt;
  logic [AD_WD-1:0] w_count_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic [AD_WD:0]   w_sum;
  logic             w_req_ok;
  logic             w_beat;

  // Extra carry bit so base+len cannot wrap past the depth check.
  assign w_sum    = {1'b0, ld_base} + {1'b0, ld_len};
  assign w_req_ok = (ld_len != '0) && (w_sum <= (AD_WD+1)'(DEPTH));
  assign w_beat   = (r_state == LOAD) && ld_valid && !ld_abort;

  assign ld_done  = r_done;
  assign ld_err   = r_err;
  assign ld_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_remaining <= w_remaining_nxt;
      r_count     <= w_count_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_remaining_nxt = r_remaining;
    w_count_nxt     = r_count;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld_start) begin
          if (w_req_ok) begin
            w_wr_ptr_nxt    = ld_base;
            w_remaining_nxt = ld_len;
            w_count_nxt     = '0;
            w_state_nxt     = LOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        if (ld_abort) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_beat) begin
          w_wr_ptr_nxt    = r_wr_ptr + AD_WD'(1);
          w_remaining_nxt = r_remaining - AD_WD'(1);
          w_count_nxt     = r_count + AD_WD'(1);
          if (r_remaining == AD_WD'(1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_address = cpu_pc;
    mem_write   = 1'b0;
    mem_data_in = ld_data;
    cpu_instr   = mem_data_out;
    cpu_stall   = 1'b0;
    ld_ready    = 1'b0;
    ld_busy     = 1'b0;
    case (r_state)
      LOAD: begin
        mem_address = r_wr_ptr;
        mem_write   = w_beat;
        cpu_instr   = NOP;
        cpu_stall   = 1'b1;
        ld_ready    = !ld_abort;
        ld_busy     = 1'b1;
      end
      DONE: begin
        cpu_instr = NOP;
        cpu_stall = 1'b1;
        ld_busy   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: behavioural memory plus an expected-contents model,
// directed loads/rejects/aborts/resets followed by randomized load traffic.
module tb_imem_load_ctrl;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned DEP  = 100;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] cpu_pc;
  logic [DW-1:0] cpu_instr;
  logic          cpu_stall;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW-1:0] ld_len;
  logic          ld_abort;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic          ld_err;
  logic [AW-1:0] ld_count;
  logic [AW-1:0] mem_address;
  logic          mem_write;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          wr_total   = 0;
  int          wr_oob     = 0;
  int          exp_writes = 0;
  logic [15:0] exp_count  = '0;
  logic [31:0] mem     [DEP];
  logic [31:0] exp_mem [DEP];

  imem_load_ctrl #(
    .AD_WD  (AW),
    .DATA_WD(DW),
    .DEPTH  (DEP),
    .NOP    (NOPW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_pc      (cpu_pc),
    .cpu_instr   (cpu_instr),
    .cpu_stall   (cpu_stall),
    .ld_start    (ld_start),
    .ld_base     (ld_base),
    .ld_len      (ld_len),
    .ld_abort    (ld_abort),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_busy     (ld_busy),
    .ld_done     (ld_done),
    .ld_err      (ld_err),
    .ld_count    (ld_count),
    .mem_address (mem_address),
    .mem_write   (mem_write),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  function automatic logic [31:0] init_word(input int unsigned i);
    return 32'hC0DE_0000 ^ (i * 32'h9E37_79B9);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  // Single-port memory: combinational read, write on rising edge.
  assign mem_data_out = (mem_address < 16'(DEP)) ? mem[mem_address[6:0]] : '0;

  initial begin
    for (int unsigned i = 0; i < DEP; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write === 1'b1) begin
        if (mem_address < 16'(DEP)) begin
          mem[mem_address[6:0]] <= mem_data_in;
          wr_total++;
        end else begin
          wr_oob++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input int pc);
    @(negedge clk);
    cpu_pc = 16'(pc);
    #1;
    chk("fetch_instr", cpu_instr, exp_mem[pc]);
    chk("fetch_addr", mem_address, 32'(pc));
    chk("fetch_stall", cpu_stall, 0);
    chk("fetch_wen", mem_write, 0);
  endtask

  task automatic reject(input int base, input int len);
    @(negedge clk);
    ld_start = 1'b1; ld_base = 16'(base); ld_len = 16'(len);
    ld_valid = 1'b1; ld_abort = 1'b0;
    #1;
    chk("rej_stall", cpu_stall, 0);
    chk("rej_wen", mem_write, 0);
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("rej_err", ld_err, 1);
    chk("rej_busy", ld_busy, 0);
    chk("rej_count", ld_count, exp_count);
    #1;
    chk("rej_idle_stall", cpu_stall, 0);
    @(negedge clk);
    chk("rej_err_pulse", ld_err, 0);
  endtask

  // gap_pct < 0 selects strictly alternating ld_valid; abort_at < 0 disables abort.
  task automatic load(input int base, input int len, input int gap_pct,
                      input int abort_at, input bit start_with_abort);
    int          k;
    int          ncyc;
    int          idle_run;
    bit          v;
    bit          ab;
    bit          aborted;
    logic [31:0] d;
    k = 0; ncyc = 0; idle_run = 0; aborted = 1'b0;
    @(negedge clk);
    ld_start = 1'b1; ld_base = 16'(base); ld_len = 16'(len);
    ld_abort = start_with_abort; ld_valid = 1'b0;
    #1;
    chk("start_idle_stall", cpu_stall, 0);
    chk("start_idle_ready", ld_ready, 0);
    @(negedge clk);
    ncyc = 1;
    ld_start = 1'b0; ld_abort = 1'b0;
    chk("load_count_clr", ld_count, 0);
    chk("load_no_err", ld_err, 0);
    exp_count = '0;
    while (1) begin
      if (gap_pct < 0) v = (ncyc % 2 == 0);
      else v = (int'($urandom_range(0, 99)) >= gap_pct) || (idle_run >= 3);
      if (k == abort_at) v = 1'b1;
      ab = (k == abort_at);
      idle_run = v ? 0 : idle_run + 1;
      d = $urandom;
      ld_valid = v; ld_data = d; ld_abort = ab;
      ld_start = 1'($urandom_range(0, 1)); ld_base = '0; ld_len = 16'd1;
      cpu_pc = 16'($urandom_range(0, DEP - 1));
      #1;
      chk("load_stall", cpu_stall, 1);
      chk("load_nop", cpu_instr, NOPW);
      chk("load_busy", ld_busy, 1);
      chk("load_ready", ld_ready, !ab);
      chk("load_wen", mem_write, v && !ab);
      chk("load_addr", mem_address, 32'(base + k));
      chk("load_wdata", mem_data_in, d);
      if (ab) begin
        aborted = 1'b1;
        break;
      end
      if (v) begin
        exp_mem[base + k] = d;
        exp_writes++;
        k++;
        exp_count = 16'(k);
        if (k == len) break;
      end
      @(negedge clk);
      ncyc++;
      chk("load_count_run", ld_count, exp_count);
      chk("load_no_done", ld_done, 0);
      chk("load_no_err_run", ld_err, 0);
    end
    @(negedge clk);
    ncyc++;
    ld_start = 1'b0; ld_valid = 1'b0; ld_abort = 1'b0;
    if (aborted) begin
      chk("abort_err", ld_err, 1);
      chk("abort_count", ld_count, exp_count);
      chk("abort_stall", cpu_stall, 0);
      chk("abort_busy", ld_busy, 0);
      chk("abort_no_done", ld_done, 0);
    end else begin
      chk("done_pulse", ld_done, 1);
      chk("done_no_err", ld_err, 0);
      chk("done_count", ld_count, 32'(len));
      chk("done_stall", cpu_stall, 1);
      chk("done_busy", ld_busy, 1);
      if (gap_pct == 0) chk("done_latency", ncyc, 32'(len + 1));
      ld_valid = 1'b1; ld_abort = 1'b1; ld_start = 1'b1; ld_base = '0; ld_len = 16'd1;
      #1;
      chk("done_wen", mem_write, 0);
      chk("done_ready", ld_ready, 0);
      chk("done_nop", cpu_instr, NOPW);
      @(negedge clk);
      ld_valid = 1'b0; ld_abort = 1'b0; ld_start = 1'b0;
      chk("post_done_stall", cpu_stall, 0);
      chk("post_done_busy", ld_busy, 0);
      chk("post_done_pulse", ld_done, 0);
      chk("post_done_err", ld_err, 0);
    end
  endtask

  initial begin
    int base;
    int len;
    int ab_at;
    for (int unsigned i = 0; i < DEP; i++) exp_mem[i] = init_word(i);
    rst_n = 1'b0; cpu_pc = 16'd5;
    ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_abort = 1'b0;
    ld_valid = 1'b0; ld_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_busy", ld_busy, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_err", ld_err, 0);
    chk("rst_count", ld_count, 0);
    chk("rst_wen", mem_write, 0);
    chk("rst_instr", cpu_instr, exp_mem[5]);
    @(negedge clk);
    rst_n = 1'b1;
    fetch(5);

    // Full-rate load; start arrives together with a (to-be-ignored) abort.
    load(10, 4, 0, -1, 1'b1);
    for (int a = 10; a < 14; a++) fetch(a);

    load(0, 3, -1, -1, 1'b0);
    chk("throttle_writes", wr_total, exp_writes);
    fetch(0); fetch(2);

    reject(98, 3);
    reject(0, 0);
    reject(65535, 2);
    reject(1, 100);
    chk("reject_writes", wr_total, exp_writes);

    load(97, 3, 0, -1, 1'b0);
    for (int a = 97; a < 100; a++) fetch(a);

    load(20, 5, 0, 2, 1'b0);
    fetch(20); fetch(21); fetch(22);
    chk("abort_writes", wr_total, exp_writes);

    // Reset in the middle of a six-word load.
    cpu_pc = 16'd7;
    @(negedge clk);
    ld_start = 1'b1; ld_base = 16'd40; ld_len = 16'd6;
    @(negedge clk);
    ld_start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      ld_valid = 1'b1; ld_data = $urandom;
      exp_mem[40 + j] = ld_data;
      exp_writes++;
      @(negedge clk);
    end
    ld_valid = 1'b1; ld_data = $urandom;
    #1;
    chk("rst_mid_wen_pre", mem_write, 1);
    chk("rst_mid_count_pre", ld_count, 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", cpu_stall, 0);
    chk("rst_mid_wen", mem_write, 0);
    chk("rst_mid_busy", ld_busy, 0);
    chk("rst_mid_ready", ld_ready, 0);
    chk("rst_mid_count", ld_count, 0);
    chk("rst_mid_instr", cpu_instr, exp_mem[7]);
    @(negedge clk);
    ld_valid = 1'b0; rst_n = 1'b1; exp_count = '0;
    chk("rst_mid_writes", wr_total, exp_writes);
    fetch(40); fetch(41); fetch(42);
    load(40, 6, 30, -1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      base  = $urandom_range(0, DEP - 1);
      len   = $urandom_range(1, ((DEP - base) > 8) ? 8 : (DEP - base));
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      load(base, len, $urandom_range(0, 60), ab_at, 1'($urandom_range(0, 1)));
      fetch(base);
      fetch($urandom_range(0, DEP - 1));
      if (r % 4 == 0) begin
        base = $urandom_range(0, DEP - 1);
        reject(base, DEP - base + 1 + $urandom_range(0, 5));
      end
    end

    @(negedge clk);
    chk("total_writes", wr_total, exp_writes);
    chk("oob_writes", wr_oob, 0);
    for (int unsigned i = 0; i < DEP; i++) chk("mem_contents", mem[i], exp_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
